// File: rtl/digit_scan_ctrl.sv
// Scan controller for the 4-position 7-segment display: digit select, active-low anodes,
// anti-ghosting guard and blink masking. Define SCAN_SKIP_BLANK_EN to scan only digits 0..2.
module digit_scan_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int SCAN_HZ   = 1000,
    parameter int GUARD_CYC = 16,
    parameter int BLINK_HZ  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] blink_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       slot_start,
    output logic       blink_phase
);

    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

`ifdef SCAN_SKIP_BLANK_EN
    localparam logic [1:0] SEL_LAST = 2'd2;
`else
    localparam logic [1:0] SEL_LAST = 2'd3;
`endif

    typedef enum logic {
        GUARD,
        DRIVE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      sel_next;
    logic [BW-1:0]   bcnt, bcnt_next;
    logic            phase_next;
    logic [3:0]      an_next;
    logic            slot_next;
    logic [3:0]      mask4;
    logic            hidden;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= GUARD;
            cnt         <= '0;
            sel         <= 2'd0;
            bcnt        <= '0;
            blink_phase <= 1'b1;
            an          <= 4'b1111;
            slot_start  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sel         <= sel_next;
            bcnt        <= bcnt_next;
            blink_phase <= phase_next;
            an          <= an_next;
            slot_start  <= slot_next;
        end
    end

    // Outputs are computed from the next-cycle state so the registered an/slot_start
    // line up with the cnt/sel/blink_phase values visible in the same cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel;
        slot_next  = 1'b0;
        an_next    = 4'b1111;
        bcnt_next  = bcnt + 1'b1;
        phase_next = blink_phase;
        mask4      = {1'b0, blink_mask};
        hidden     = 1'b0;

        if (bcnt == BLINK_LAST) begin
            bcnt_next  = '0;
            phase_next = ~blink_phase;
        end

        if (en) begin
            if (cnt == CNT_LAST) begin
                cnt_next   = '0;
                sel_next   = (sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
                state_next = GUARD;
                slot_next  = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
                if (cnt_next == CNT_GUARD) begin
                    state_next = DRIVE;
                end
            end
        end

        // Position 3 has no mask bit, so it is never hidden by blinking.
        hidden = mask4[sel_next] && !phase_next;

        if (en && state_next == DRIVE && !hidden) begin
            an_next = ~(4'b0001 << sel_next);
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: scripted scenarios plus random stimulus,
// compared every cycle against a slot/position arithmetic model.
module tb_digit_scan_ctrl;

    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int GUARD_CYC = 2;
    localparam int BLINK_HZ  = 25;
    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);
`ifdef SCAN_SKIP_BLANK_EN
    localparam int NSLOT = 3;
`else
    localparam int NSLOT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] blink_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       slot_start;
    logic       blink_phase;

    int errors = 0;
    int checks = 0;

    // Model state: enabled advances since reset, clocks since reset, last sampled inputs.
    int         pos = 0;
    int         ticks = 0;
    logic       en_last = 1'b0;
    logic [2:0] mask_last = 3'b000;
    logic       mvalid = 1'b0;

    digit_scan_ctrl #(
        .CLK_HZ(CLK_HZ),
        .SCAN_HZ(SCAN_HZ),
        .GUARD_CYC(GUARD_CYC),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .blink_mask(blink_mask),
        .sel(sel),
        .an(an),
        .slot_start(slot_start),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt();
        return pos % DIV;
    endfunction

    function automatic int m_sel();
        return (pos / DIV) % NSLOT;
    endfunction

    function automatic int m_phase();
        return (((ticks / HALF) % 2) == 0) ? 1 : 0;
    endfunction

    function automatic int m_slot();
        return (en_last && m_cnt() == 0) ? 1 : 0;
    endfunction

    function automatic int m_an();
        int s;
        s = m_sel();
        if (!en_last || m_cnt() < GUARD_CYC) return 4'hF;
        if (s < 3 && mask_last[s] && m_phase() == 0) return 4'hF;
        return (~(1 << s)) & 4'hF;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m);
        rst_n      = r;
        en         = e;
        blink_mask = m;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            pos       = 0;
            ticks     = 0;
            en_last   = 1'b0;
            mask_last = 3'b000;
            mvalid    = 1'b1;
        end else if (mvalid) begin
            if (en) pos++;
            ticks++;
            en_last   = en;
            mask_last = blink_mask;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checkOutput("sel", int'(sel), m_sel());
            checkOutput("an", int'(an), m_an());
            checkOutput("slot_start", int'(slot_start), m_slot());
            checkOutput("blink_phase", int'(blink_phase), m_phase());
            checkOutput("an_shape", int'(an == 4'hF || an == 4'hE || an == 4'hD ||
                                         an == 4'hB || an == 4'h7), 1);
        end
    end

    initial begin
        int n;
        logic p0;

        // Reset and basic scan with hand-computed expectations.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("rst_sel", int'(sel), 0);
        checkOutput("rst_an", int'(an), 4'hF);
        checkOutput("rst_slot", int'(slot_start), 0);
        checkOutput("rst_phase", int'(blink_phase), 1);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 1'b1, 3'b000);
            if (k == 1)  checkOutput("lit_guard_an", int'(an), 4'hF);
            if (k == 2)  checkOutput("lit_drive0_an", int'(an), 4'hE);
            if (k == 9)  checkOutput("lit_drive0_end", int'(an), 4'hE);
            if (k == 10) checkOutput("lit_slot1_start", int'(slot_start), 1);
            if (k == 10) checkOutput("lit_slot1_sel", int'(sel), 1);
            if (k == 12) checkOutput("lit_drive1_an", int'(an), 4'hD);
            if (k == 20) checkOutput("lit_phase_toggle", int'(blink_phase), 0);
            if (k == 30) checkOutput("lit_sel_30", int'(sel), (NSLOT == 4) ? 3 : 0);
            if (k == 40) checkOutput("lit_sel_40", int'(sel), (NSLOT == 4) ? 0 : 1);
        end

        // Blink on digit 1; measure a full phase interval.
        p0 = blink_phase;
        n = 0;
        while (blink_phase == p0 && n < 100) begin
            applyStimulus(1'b1, 1'b1, 3'b010);
            n++;
        end
        p0 = blink_phase;
        n = 0;
        while (blink_phase == p0 && n < 100) begin
            applyStimulus(1'b1, 1'b1, 3'b010);
            n++;
        end
        checkOutput("lit_blink_interval", n, HALF);
        for (int k = 0; k < 60; k++) applyStimulus(1'b1, 1'b1, 3'b010);

        // Enable gating mid-slot on digit 2.
        n = 0;
        while (!(m_sel() == 2 && m_cnt() == 5) && n < 200) begin
            applyStimulus(1'b1, 1'b1, 3'b010);
            n++;
        end
        checkOutput("wait_sel2_cnt5", int'(m_sel() == 2 && m_cnt() == 5), 1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b0, 3'b010);
            checkOutput("hold_an", int'(an), 4'hF);
            checkOutput("hold_sel", int'(sel), 2);
        end
        applyStimulus(1'b1, 1'b1, 3'b010);
        checkOutput("resume_an", int'(an), 4'hB);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 3'b010);
            n++;
        end while (!slot_start && n < 50);
        checkOutput("resume_remaining", n, 4);

        // Reset in the middle of the last slot.
        n = 0;
        while (!(m_sel() == NSLOT - 1 && m_cnt() == 6) && n < 200) begin
            applyStimulus(1'b1, 1'b1, 3'b000);
            n++;
        end
        checkOutput("wait_last_cnt6", int'(m_sel() == NSLOT - 1 && m_cnt() == 6), 1);
        applyStimulus(1'b0, 1'b1, 3'b000);
        checkOutput("midrst_sel", int'(sel), 0);
        checkOutput("midrst_an", int'(an), 4'hF);
        checkOutput("midrst_phase", int'(blink_phase), 1);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 3'b000);
            n++;
        end while (!slot_start && n < 50);
        checkOutput("midrst_next_slot", n, DIV);

        // Random enable, mask and reset traffic.
        for (int k = 0; k < 5000; k++) begin
            applyStimulus(($urandom_range(99) != 0), ($urandom_range(9) != 0),
                          ($urandom_range(15) == 0) ? 3'($urandom) : blink_mask);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
